// File: rtl/time_alu_seq_if.sv
// time_alu_seq_if
//   Request/response bundle between the alarm/countdown controller (master)
//   and the sequential BCD time ALU (slave).
//   Ports (all BCD times packed {h10,h1,m10,m1,s10,s1}, s1 at [3:0]):
//     start    master->slave  request, sampled only while the ALU is idle
//     op_sub   master->slave  0 = A+B, 1 = A-B
//     a_time   master->slave  operand A
//     b_time   master->slave  operand B
//     busy     slave->master  operation in progress
//     done     slave->master  one-cycle completion pulse
//     res_time slave->master  result, held until the next accepted start
//     ovf      slave->master  hour wrap occurred
//     err      slave->master  operand range violation on the last operation
interface time_alu_seq_if;
  logic        start;
  logic        op_sub;
  logic [23:0] a_time;
  logic [23:0] b_time;
  logic        busy;
  logic        done;
  logic [23:0] res_time;
  logic        ovf;
  logic        err;

  modport master (
    output start, op_sub, a_time, b_time,
    input  busy, done, res_time, ovf, err
  );

  modport slave (
    input  start, op_sub, a_time, b_time,
    output busy, done, res_time, ovf, err
  );
endinterface

// File: rtl/time_alu_seq.sv
// time_alu_seq
//   Sequential BCD HH:MM:SS adder/subtractor. Operands are range-checked,
//   then processed one digit per clock (seconds first); hours wrap at
//   HOUR_MOD and the wrap is reported on ovf.
//   Parameters:
//     HOUR_MOD  hour wrap modulus, 2..100 (100 = plain 00-99 hours)
//     SUB_EN    1 = subtraction available, 0 = op_sub ignored
//   Ports:
//     clk  input   system clock, rising edge
//     rst  input   synchronous active-high reset (aborts any operation)
//     bus  slave   start/op_sub/a_time/b_time in, busy/done/res_time/ovf/err out
module time_alu_seq #(
  parameter int HOUR_MOD = 24,
  parameter bit SUB_EN   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  time_alu_seq_if.slave bus
);

  localparam logic [7:0] LP_MOD = 8'(HOUR_MOD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_CALC  = 3'd2,
    S_WRAP  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_a;
  logic [23:0] r_b;
  logic        r_sub;
  logic        r_c;
  logic [2:0]  r_idx;
  logic [23:0] r_work;
  logic [23:0] r_res;
  logic        r_ovf;
  logic        r_err;
  logic        r_busy;
  logic        r_done;

  logic        w_bad;
  logic [4:0]  w_mod;
  logic [4:0]  w_step;
  logic [7:0]  w_h;
  logic [7:0]  w_h_new;
  logic        w_ovf_nxt;
  logic [23:0] w_res_nxt;

  // Binary hours value 10*h10 + h1 (up to 165 for out-of-range digits).
  function automatic logic [7:0] hours_of(input logic [23:0] t);
    return ({4'd0, t[23:20]} * 8'd10) + {4'd0, t[19:16]};
  endfunction

  // True when any digit or the hours value of t is out of range.
  function automatic logic time_bad(input logic [23:0] t);
    return (t[3:0]   > 4'd9) || (t[7:4]   > 4'd5) ||
           (t[11:8]  > 4'd9) || (t[15:12] > 4'd5) ||
           (t[19:16] > 4'd9) || (t[23:20] > 4'd9) ||
           (hours_of(t) >= LP_MOD);
  endfunction

  // Select digit idx (0 = s1 .. 5 = h10) of a packed time.
  function automatic logic [3:0] get_digit(input logic [23:0] t, input logic [2:0] idx);
    logic [3:0] d;
    case (idx)
      3'd0:    d = t[3:0];
      3'd1:    d = t[7:4];
      3'd2:    d = t[11:8];
      3'd3:    d = t[15:12];
      3'd4:    d = t[19:16];
      3'd5:    d = t[23:20];
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  // One digit of add/sub with modulus m; returns {carry/borrow, digit}.
  // Add runs in 5-bit unsigned (max 19), sub in 5-bit signed (min -10) so
  // neither result can silently wrap through a 4-bit field.
  function automatic logic [4:0] digit_step(input logic [3:0] a, input logic [3:0] b,
                                            input logic cin, input logic sub,
                                            input logic [4:0] m);
    logic [4:0]        sum;
    logic signed [4:0] diff;
    logic [4:0]        t;
    logic              co;
    if (sub) begin
      diff = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({4'd0, cin});
      if (diff < 5'sd0) begin
        t  = diff + m;
        co = 1'b1;
      end else begin
        t  = diff;
        co = 1'b0;
      end
    end else begin
      sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      if (sum >= m) begin
        t  = sum - m;
        co = 1'b1;
      end else begin
        t  = sum;
        co = 1'b0;
      end
    end
    return {co, t[3:0]};
  endfunction

  // Binary 0..99 to two BCD digits {tens, ones}.
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    logic [7:0] q;
    logic [7:0] r;
    q = v / 8'd10;
    r = v - (q * 8'd10);
    return {q[3:0], r[3:0]};
  endfunction

  assign w_bad  = time_bad(r_a) || time_bad(r_b);
  // Tens of seconds and tens of minutes count modulo 6, all others modulo 10.
  assign w_mod  = ((r_idx == 3'd1) || (r_idx == 3'd3)) ? 5'd6 : 5'd10;
  assign w_step = digit_step(get_digit(r_a, r_idx), get_digit(r_b, r_idx), r_c, r_sub, w_mod);

  // Hour wrap: the final carry/borrow out of h10 stands for +/-100 hours.
  always_comb begin
    w_h       = hours_of(r_work);
    w_h_new   = w_h;
    w_ovf_nxt = 1'b0;
    if (r_sub) begin
      if (r_c) begin
        w_h_new   = w_h + LP_MOD - 8'd100;
        w_ovf_nxt = 1'b1;
      end else begin
        w_h_new   = w_h;
        w_ovf_nxt = 1'b0;
      end
    end else begin
      if (r_c || (w_h >= LP_MOD)) begin
        w_h_new   = w_h + (r_c ? 8'd100 : 8'd0) - LP_MOD;
        w_ovf_nxt = 1'b1;
      end else begin
        w_h_new   = w_h;
        w_ovf_nxt = 1'b0;
      end
    end
    w_res_nxt = {to_bcd(w_h_new), r_work[15:0]};
  end

  // Next-state logic. A bad operand skips CALC but still spends one cycle
  // in WRAP (which leaves the error result alone) before FIN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_CHECK;
        else           w_state_nxt = S_IDLE;
      end
      S_CHECK: begin
        if (w_bad) w_state_nxt = S_WRAP;
        else       w_state_nxt = S_CALC;
      end
      S_CALC: begin
        if (r_idx == 3'd5) w_state_nxt = S_WRAP;
        else               w_state_nxt = S_CALC;
      end
      S_WRAP:  w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= 24'd0;
      r_b    <= 24'd0;
      r_sub  <= 1'b0;
      r_c    <= 1'b0;
      r_idx  <= 3'd0;
      r_work <= 24'd0;
      r_res  <= 24'd0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      // Outputs lag the state by one cycle: busy covers CHECK..WRAP, done follows FIN.
      r_busy <= (r_state == S_CHECK) || (r_state == S_CALC) || (r_state == S_WRAP);
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.a_time;
            r_b   <= bus.b_time;
            r_sub <= bus.op_sub & SUB_EN;
            r_c   <= 1'b0;
            r_idx <= 3'd0;
          end
        end
        S_CHECK: begin
          r_idx <= 3'd0;
          if (w_bad) begin
            r_err <= 1'b1;
            r_res <= 24'd0;
            r_ovf <= 1'b0;
          end else begin
            r_err <= 1'b0;
          end
        end
        S_CALC: begin
          r_c   <= w_step[4];
          r_idx <= r_idx + 3'd1;
          case (r_idx)
            3'd0:    r_work[3:0]   <= w_step[3:0];
            3'd1:    r_work[7:4]   <= w_step[3:0];
            3'd2:    r_work[11:8]  <= w_step[3:0];
            3'd3:    r_work[15:12] <= w_step[3:0];
            3'd4:    r_work[19:16] <= w_step[3:0];
            3'd5:    r_work[23:20] <= w_step[3:0];
            default: r_work        <= r_work;
          endcase
        end
        S_WRAP: begin
          if (!r_err) begin
            r_res <= w_res_nxt;
            r_ovf <= w_ovf_nxt;
          end
        end
        S_FIN:   r_c <= 1'b0;
        default: r_c <= 1'b0;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.res_time = r_res;
  assign bus.ovf      = r_ovf;
  assign bus.err      = r_err;

endmodule
